// File: rtl/div_wb_arbiter.sv
// rtl/div_wb_arbiter.sv - shares one register-file write port between the main pipe and buffered divider results
// The pipe wins the port unless the result FIFO is full; buffered results are killed by younger pipe writes.
module div_wb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic        div_we,
  input  logic [4:0]  div_addr,
  input  logic [31:0] div_data,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic        stall_req,
  output logic        hazard,
  output logic [1:0]  fifo_count,
  output logic        ovf_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [4:0]            addr_q [FIFO_DEPTH];
  logic [31:0]           data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live_q;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [1:0]            count_q;
  logic                  ovf_q;

  logic pipe_valid, div_valid, full, head_live, head_dead;
  logic pipe_perform, pop, push, kill_new, ovf_set;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pipe_valid   = pipe_we && (pipe_addr != 5'd0);
  assign div_valid    = div_we && (div_addr != 5'd0);
  assign full         = (count_q == 2'(FIFO_DEPTH));
  assign head_live    = (count_q != 2'd0) && live_q[rd_ptr];
  assign head_dead    = (count_q != 2'd0) && !live_q[rd_ptr];
  assign pipe_perform = pipe_valid && !full;
  // A dead head leaves silently; a live head leaves only when it gets the port.
  assign pop          = head_dead || (head_live && !pipe_perform);
  assign push         = div_valid && (!full || pop);
  assign kill_new     = pipe_perform && (pipe_addr == div_addr);
  assign ovf_set      = (pipe_valid && full) || (div_valid && !push);

  always_comb begin
    rf_we   = 1'b0;
    rf_addr = 5'd0;
    rf_data = 32'd0;
    if (!rst) begin
      if (pipe_perform) begin
        rf_we   = 1'b1;
        rf_addr = pipe_addr;
        rf_data = pipe_data;
      end else if (head_live) begin
        rf_we   = 1'b1;
        rf_addr = addr_q[rd_ptr];
        rf_data = data_q[rd_ptr];
      end
    end
  end

  // Live bits are cleared on pop, so a set bit always marks an occupied slot.
  always_comb begin
    hazard = div_valid && ((div_addr == rs1_addr) || (div_addr == rs2_addr));
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] != 5'd0) &&
          ((addr_q[i] == rs1_addr) || (addr_q[i] == rs2_addr)))
        hazard = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= 2'd0;
      live_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (pop) begin
        live_q[rd_ptr] <= 1'b0;
        rd_ptr         <= ptr_next(rd_ptr);
      end
      if (pipe_perform) begin
        for (int i = 0; i < FIFO_DEPTH; i++)
          if (addr_q[i] == pipe_addr) live_q[i] <= 1'b0;
      end
      if (push) begin
        addr_q[wr_ptr] <= div_addr;
        data_q[wr_ptr] <= div_data;
        live_q[wr_ptr] <= !kill_new;
        wr_ptr         <= ptr_next(wr_ptr);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  assign stall_req  = full;
  assign fifo_count = count_q;
  assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_div_wb_arbiter.sv
// tb/tb_div_wb_arbiter.sv - directed vector table plus randomized run against a queue-based reference model
module tb_div_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        div_we;
  logic [4:0]  div_addr;
  logic [31:0] div_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        stall_req;
  logic        hazard;
  logic [1:0]  fifo_count;
  logic        ovf_err;

  div_wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .div_we(div_we), .div_addr(div_addr), .div_data(div_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .stall_req(stall_req), .hazard(hazard), .fifo_count(fifo_count), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        div_we;
    logic [4:0]  div_addr;
    logic [31:0] div_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_haz;
    logic [1:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          live;
  } ent_t;

  vec_t vecs[$];
  ent_t mq[$];
  bit   m_ovf;
  bit   m_full, m_pv, m_dv, m_perf;

  logic        exp_we, exp_stall, exp_haz, exp_ovf;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic [1:0]  exp_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  function automatic vec_t mk(input int r, pw, pa, pd, dw, da, dd, s1, s2,
                              ew, ea, ed, es, eh, ec, eo);
    vec_t v;
    v.rst = r[0];       v.pipe_we = pw[0];    v.pipe_addr = pa[4:0]; v.pipe_data = pd;
    v.div_we = dw[0];   v.div_addr = da[4:0]; v.div_data = dd;
    v.rs1 = s1[4:0];    v.rs2 = s2[4:0];
    v.e_we = ew[0];     v.e_addr = ea[4:0];   v.e_data = ed;
    v.e_stall = es[0];  v.e_haz = eh[0];      v.e_cnt = ec[1:0];  v.e_ovf = eo[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic check_all(input string tag, input logic ew, input logic [4:0] ea,
                           input logic [31:0] ed, input logic es, input logic eh,
                           input logic [1:0] ec, input logic eo);
    chk({tag, "_rf_we"},     32'(rf_we),      32'(ew));
    chk({tag, "_rf_addr"},   32'(rf_addr),    32'(ea));
    chk({tag, "_rf_data"},   rf_data,         ed);
    chk({tag, "_stall"},     32'(stall_req),  32'(es));
    chk({tag, "_hazard"},    32'(hazard),     32'(eh));
    chk({tag, "_count"},     32'(fifo_count), 32'(ec));
    chk({tag, "_ovf"},       32'(ovf_err),    32'(eo));
  endtask

  // Reference: an ordered list of buffered results, evaluated from the arbitration rules.
  task automatic model_eval();
    m_full = (mq.size() == 2);
    m_pv   = pipe_we && (pipe_addr != 5'd0);
    m_dv   = div_we && (div_addr != 5'd0);
    m_perf = m_pv && !m_full;
    exp_we = 1'b0; exp_addr = 5'd0; exp_data = 32'd0;
    if (!rst) begin
      if (m_perf) begin
        exp_we = 1'b1; exp_addr = pipe_addr; exp_data = pipe_data;
      end else if (mq.size() > 0 && mq[0].live) begin
        exp_we = 1'b1; exp_addr = mq[0].a; exp_data = mq[0].d;
      end
    end
    exp_cnt   = 2'(mq.size());
    exp_stall = m_full;
    exp_ovf   = m_ovf;
    exp_haz   = m_dv && (div_addr == rs1_addr || div_addr == rs2_addr);
    foreach (mq[i])
      if (mq[i].live && (mq[i].a == rs1_addr || mq[i].a == rs2_addr)) exp_haz = 1'b1;
  endtask

  task automatic model_commit();
    bit pop, push;
    if (rst) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      pop  = (mq.size() > 0) && (!mq[0].live || !m_perf);
      push = m_dv && (!m_full || pop);
      if ((m_pv && m_full) || (m_dv && !push)) m_ovf = 1;
      if (pop) void'(mq.pop_front());
      if (m_perf)
        foreach (mq[i]) if (mq[i].a == pipe_addr) mq[i].live = 0;
      if (push) mq.push_back('{div_addr, div_data, !(m_perf && pipe_addr == div_addr)});
    end
  endtask

  initial begin
    rst = 1'b1; pipe_we = 1'b0; pipe_addr = 5'd0; pipe_data = 32'd0;
    div_we = 1'b0; div_addr = 5'd0; div_data = 32'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;

    //        rst pw pa pd      dw da dd     s1 s2   ew ea ed     st hz cn ov
    vecs.push_back(mk(0, 0,0,0,       1,5,'h10,  0,0,    0,0,0,       0,0,0,0));
    vecs.push_back(mk(0, 0,0,0,       0,0,0,     0,0,    1,5,'h10,    0,0,1,0));
    vecs.push_back(mk(0, 0,0,0,       0,0,0,     0,0,    0,0,0,       0,0,0,0));
    vecs.push_back(mk(0, 1,3,'h30,    1,7,'hAA,  0,0,    1,3,'h30,    0,0,0,0));
    vecs.push_back(mk(0, 1,3,'h31,    0,0,0,     0,0,    1,3,'h31,    0,0,1,0));
    vecs.push_back(mk(0, 1,3,'h32,    0,0,0,     0,0,    1,3,'h32,    0,0,1,0));
    vecs.push_back(mk(0, 0,0,0,       0,0,0,     0,0,    1,7,'hAA,    0,0,1,0));
    vecs.push_back(mk(0, 0,0,0,       0,0,0,     0,0,    0,0,0,       0,0,0,0));
    vecs.push_back(mk(0, 0,0,0,       1,9,1,     0,0,    0,0,0,       0,0,0,0));
    vecs.push_back(mk(0, 1,9,2,       0,0,0,     0,0,    1,9,2,       0,0,1,0));
    vecs.push_back(mk(0, 0,0,0,       0,0,0,     0,0,    0,0,0,       0,0,1,0));
    vecs.push_back(mk(0, 0,0,0,       0,0,0,     0,0,    0,0,0,       0,0,0,0));
    vecs.push_back(mk(0, 0,0,0,       1,4,'h44,  0,4,    0,0,0,       0,1,0,0));
    vecs.push_back(mk(0, 1,1,'h11,    0,0,0,     0,4,    1,1,'h11,    0,1,1,0));
    vecs.push_back(mk(0, 1,1,'h12,    0,0,0,     0,0,    1,1,'h12,    0,0,1,0));
    vecs.push_back(mk(0, 0,0,0,       0,0,0,     0,4,    1,4,'h44,    0,1,1,0));
    vecs.push_back(mk(0, 0,0,0,       0,0,0,     0,4,    0,0,0,       0,0,0,0));
    vecs.push_back(mk(0, 1,1,'h13,    1,2,'h22,  0,0,    1,1,'h13,    0,0,0,0));
    vecs.push_back(mk(0, 1,1,'h14,    1,6,'h66,  0,0,    1,1,'h14,    0,0,1,0));
    vecs.push_back(mk(0, 1,1,'h15,    0,0,0,     0,0,    1,2,'h22,    1,0,2,0));
    vecs.push_back(mk(0, 0,0,0,       0,0,0,     0,0,    1,6,'h66,    0,0,1,1));
    vecs.push_back(mk(0, 0,0,0,       0,0,0,     0,0,    0,0,0,       0,0,0,1));
    vecs.push_back(mk(0, 1,1,'h16,    1,8,'h88,  0,0,    1,1,'h16,    0,0,0,1));
    vecs.push_back(mk(0, 1,1,'h17,    1,10,'hA0, 0,0,    1,1,'h17,    0,0,1,1));
    vecs.push_back(mk(1, 1,1,'h18,    0,0,0,     0,0,    0,0,0,       1,0,2,1));
    vecs.push_back(mk(0, 0,0,0,       0,0,0,     0,0,    0,0,0,       0,0,0,0));
    vecs.push_back(mk(0, 0,0,0,       0,0,0,     0,0,    0,0,0,       0,0,0,0));
    vecs.push_back(mk(0, 1,0,'hFF,    1,0,'hEE,  0,0,    0,0,0,       0,0,0,0));
    vecs.push_back(mk(0, 0,0,0,       0,0,0,     0,0,    0,0,0,       0,0,0,0));

    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; pipe_we = vecs[i].pipe_we; pipe_addr = vecs[i].pipe_addr;
      pipe_data = vecs[i].pipe_data; div_we = vecs[i].div_we; div_addr = vecs[i].div_addr;
      div_data = vecs[i].div_data; rs1_addr = vecs[i].rs1; rs2_addr = vecs[i].rs2;
      #2;
      check_all($sformatf("row%0d", i), vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data,
                vecs[i].e_stall, vecs[i].e_haz, vecs[i].e_cnt, vecs[i].e_ovf);
      @(negedge clk);
    end

    rst = 1'b1; pipe_we = 1'b0; div_we = 1'b0;
    mq.delete(); m_ovf = 0;
    @(negedge clk);

    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 149) == 0);
      pipe_we   = 1'($urandom_range(0, 1));
      pipe_addr = 5'($urandom_range(0, 7));
      pipe_data = $urandom;
      div_we    = ($urandom_range(0, 9) < 4);
      div_addr  = 5'($urandom_range(0, 7));
      div_data  = $urandom;
      rs1_addr  = 5'($urandom_range(0, 7));
      rs2_addr  = 5'($urandom_range(0, 7));
      #2;
      model_eval();
      check_all($sformatf("rnd%0d", n), exp_we, exp_addr, exp_data,
                exp_stall, exp_haz, exp_cnt, exp_ovf);
      @(posedge clk);
      model_commit();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/div_wb_arbiter.md
DIV_WB_ARBITER -- requirements
Module: div_wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of buffered divider results (fixed 2 for this revision).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have ports pipe_we/pipe_addr/pipe_data, input, 1/5/32, main-pipeline WB write request.
REQ-005 SHALL have ports div_we/div_addr/div_data, input, 1/5/32, divider-manager result (one-cycle pulse per result).
REQ-006 SHALL have ports rs1_addr/rs2_addr, input, 5/5, ID-stage source registers for the hazard check.
REQ-007 SHALL have ports rf_we/rf_addr/rf_data, output, 1/5/32, the single register-file write port.
REQ-008 SHALL have port stall_req, output, 1, which is high when the FIFO is full and requests upstream to hold its WB.
REQ-009 SHALL have port hazard, output, 1, which is high when rs1 or rs2 has a pending divider write.
REQ-010 SHALL have port fifo_count, output, 2, the occupied-slot count (0..2).
REQ-011 SHALL have port ovf_err, output, 1, a sticky flag for protocol violation or overflow.

Function
REQ-012 SHALL treat any request with addr 0 as a non-request: no write, no enqueue, no kill.
REQ-013 SHALL give the pipe request absolute priority: while not full, a valid pipe_we drives rf_* combinationally in the same cycle.
REQ-014 SHALL drive rf_* from the FIFO head when no pipe write is performed and the head is live; otherwise rf_we=0 and rf_addr/rf_data=0.
REQ-015 SHALL enqueue an accepted div request at the tail; div is never written directly, so each result costs at least 1 cycle of latency.
REQ-016 SHALL store per slot: addr (5 bits), data (32 bits), and live bit; the FIFO is a circular buffer with wrap-around rd/wr pointers.
REQ-017 SHALL clear the live bit of every stored entry with matching addr when a pipe write to addr A is performed, preserving WAW order (pipe instruction is younger).
REQ-018 SHALL enqueue a div request whose addr equals a same-cycle performed pipe write as a dead entry.
REQ-019 SHALL pop the head when it is dead (no write, regardless of pipe) or when it is written per REQ-014.
REQ-020 SHALL allow push and pop in the same cycle, leaving count unchanged, including when full.
REQ-021 SHALL assert stall_req = (fifo_count==2), derived from registered state only.
REQ-022 SHALL, while full, make the head own the port; a pipe_we in that cycle is ignored (not written, no kill) and sets ovf_err.
REQ-023 SHALL set ovf_err on div_we when full and no pop occurs that cycle, and drop the request.
REQ-024 SHALL assert hazard = OR over live entries, plus the current div request, of (addr!=0 and addr matches rs1_addr or rs2_addr); this is combinational.
REQ-025 SHALL make fifo_count equal to the registered occupancy, counting dead and live entries.

Reset
REQ-026 SHALL, on rst, clear pointers, count, all live bits and ovf_err, giving rf_we=0, stall_req=0, hazard=0 and fifo_count=0 in the following cycle.
REQ-027 SHALL discard buffered results when rst is asserted mid-operation, with no write in the reset cycle.
REQ-028 SHALL let rst override all same-cycle requests.

Verification
REQ-029 SHALL pass: div_we addr=5 data=0x10 with pipe idle -> next cycle rf_we=1, rf_addr=5, rf_data=0x10, count returns 0.
REQ-030 SHALL pass: div_we addr=7 data=0xAA with pipe_we addr=3 every cycle for 3 cycles -> rf shows x3 writes, count=1, then x7=0xAA in the first pipe-idle cycle.
REQ-031 SHALL pass: buffered x9=0x1 followed by pipe_we x9=0x2 -> entry killed, rf writes only x9=0x2, dead entry popped silently, count to 0.
REQ-032 SHALL pass: two divs buffered behind continuous pipe writes -> count=2, stall_req=1; a pipe_we while full gives ovf_err=1 and the head is written.
REQ-033 SHALL pass: buffered x4 with rs2_addr=4 -> hazard=1; rs1_addr=rs2_addr=0 -> hazard=0; after the drain, hazard=0.
REQ-034 SHALL pass: rst asserted with count=2 -> next cycle count=0, stall_req=0, ovf_err=0, and no rf write of the old entries ever.
